sp_mem_arbiter: RTL

//  Memory-side arbiter that consumes scratchpad row load/store requests (sLoad/sStore) and returns
//  row data and completions (load_data, sLoad_hit, sLoad_row, sStore_hit). It serialises each

---
 rtl/sp_mem_arbiter.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/sp_mem_arbiter.sv
// Memory-side arbiter: serialises scratchpad row loads/stores into MEM_W beats on a
// single-ported ready-handshake bus, with one row transfer in flight at a time.
module sp_mem_arbiter #(
    parameter int BITS_PER_ROW = 128,
    parameter int MEM_W        = 32,
    parameter int WORD_W       = 32,
    parameter int ROW_S_W      = 2
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    sLoad,
    input  logic [WORD_W-1:0]       load_addr,
    input  logic                    sStore,
    input  logic [WORD_W-1:0]       store_addr,
    input  logic [BITS_PER_ROW-1:0] store_data,
    output logic [BITS_PER_ROW-1:0] load_data,
    output logic                    sLoad_hit,
    output logic [ROW_S_W-1:0]      sLoad_row,
    output logic                    sStore_hit,
    output logic                    busy,
    output logic                    mem_ren,
    output logic                    mem_wen,
    output logic [WORD_W-1:0]       mem_addr,
    output logic [MEM_W-1:0]        mem_wdata,
    input  logic [MEM_W-1:0]        mem_rdata,
    input  logic                    mem_ready
);
    localparam int BEATS = BITS_PER_ROW / MEM_W;
    localparam int OFF_W = $clog2(BITS_PER_ROW / 8);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0]  ONE_BEAT  = CNT_W'(1);
    localparam logic [WORD_W-1:0] BEAT_STEP = WORD_W'(MEM_W / 8);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        STORE = 2'b10,
        HIT   = 2'b11
    } state_t;

    typedef enum logic {
        GRANT_LOAD  = 1'b0,
        GRANT_STORE = 1'b1
    } grant_t;

    state_t                  state_r;
    grant_t                  last_grant_r;
    logic [CNT_W-1:0]        beat_r;
    logic [BITS_PER_ROW-1:0] shift_r;
    logic [ROW_S_W-1:0]      row_r;

    logic                    grant_load_s;
    logic                    grant_store_s;
    logic                    tie_s;
    logic [WORD_W-1:0]       load_base_s;
    logic [WORD_W-1:0]       store_base_s;
    logic [BITS_PER_ROW-1:0] shift_next_s;

    assign load_base_s  = {load_addr[WORD_W-1:OFF_W], {OFF_W{1'b0}}};
    assign store_base_s = {store_addr[WORD_W-1:OFF_W], {OFF_W{1'b0}}};
    assign shift_next_s = shift_r >> MEM_W;
    assign tie_s        = sLoad & sStore;

    // Request arbitration: a tie goes to the type that did not win the previous tie.
    always_comb begin
        grant_load_s  = 1'b0;
        grant_store_s = 1'b0;
        if (tie_s) begin
            grant_load_s  = (last_grant_r == GRANT_STORE);
            grant_store_s = (last_grant_r == GRANT_LOAD);
        end else begin
            grant_load_s  = sLoad;
            grant_store_s = sStore;
        end
    end

    // Transfer FSM with beat sequencing and all registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r      <= IDLE;
            last_grant_r <= GRANT_STORE;
            beat_r       <= {CNT_W{1'b0}};
            shift_r      <= {BITS_PER_ROW{1'b0}};
            row_r        <= {ROW_S_W{1'b0}};
            load_data    <= {BITS_PER_ROW{1'b0}};
            sLoad_hit    <= 1'b0;
            sLoad_row    <= {ROW_S_W{1'b0}};
            sStore_hit   <= 1'b0;
            busy         <= 1'b0;
            mem_ren      <= 1'b0;
            mem_wen      <= 1'b0;
            mem_addr     <= {WORD_W{1'b0}};
            mem_wdata    <= {MEM_W{1'b0}};
        end else begin
            sLoad_hit  <= 1'b0;
            sStore_hit <= 1'b0;
            case (state_r)
                IDLE: begin
                    beat_r <= {CNT_W{1'b0}};
                    if (grant_load_s) begin
                        state_r  <= LOAD;
                        row_r    <= load_addr[OFF_W +: ROW_S_W];
                        mem_addr <= load_base_s;
                        mem_ren  <= 1'b1;
                        busy     <= 1'b1;
                        if (tie_s) begin
                            last_grant_r <= GRANT_LOAD;
                        end
                    end else if (grant_store_s) begin
                        state_r   <= STORE;
                        shift_r   <= store_data;
                        mem_wdata <= store_data[MEM_W-1:0];
                        mem_addr  <= store_base_s;
                        mem_wen   <= 1'b1;
                        busy      <= 1'b1;
                        if (tie_s) begin
                            last_grant_r <= GRANT_STORE;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                LOAD: begin
                    if (mem_ready) begin
                        load_data[int'(beat_r)*MEM_W +: MEM_W] <= mem_rdata;
                        if (beat_r == LAST_BEAT) begin
                            state_r   <= HIT;
                            beat_r    <= {CNT_W{1'b0}};
                            mem_ren   <= 1'b0;
                            sLoad_hit <= 1'b1;
                            sLoad_row <= row_r;
                        end else begin
                            beat_r   <= beat_r + ONE_BEAT;
                            mem_addr <= mem_addr + BEAT_STEP;
                        end
                    end
                end
                STORE: begin
                    if (mem_ready) begin
                        if (beat_r == LAST_BEAT) begin
                            state_r    <= HIT;
                            beat_r     <= {CNT_W{1'b0}};
                            mem_wen    <= 1'b0;
                            sStore_hit <= 1'b1;
                        end else begin
                            beat_r    <= beat_r + ONE_BEAT;
                            mem_addr  <= mem_addr + BEAT_STEP;
                            shift_r   <= shift_next_s;
                            mem_wdata <= shift_next_s[MEM_W-1:0];
                        end
                    end
                end
                HIT: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    beat_r  <= {CNT_W{1'b0}};
                    mem_ren <= 1'b0;
                    mem_wen <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    sp_mem_arbiter_chk u_chk (
        .CLK        (CLK),
        .RST        (RST),
        .mem_ren    (mem_ren),
        .mem_wen    (mem_wen),
        .sLoad_hit  (sLoad_hit),
        .sStore_hit (sStore_hit),
        .busy       (busy)
    );
endmodule

// Protocol properties of the arbiter's registered outputs.
module sp_mem_arbiter_chk (
    input logic CLK,
    input logic RST,
    input logic mem_ren,
    input logic mem_wen,
    input logic sLoad_hit,
    input logic sStore_hit,
    input logic busy
);
    a_enable_exclusive: assert property (@(posedge CLK) disable iff (RST)
        !(mem_ren && mem_wen));
    a_hit_exclusive: assert property (@(posedge CLK) disable iff (RST)
        !(sLoad_hit && sStore_hit));
    a_hit_single_cycle: assert property (@(posedge CLK) disable iff (RST)
        (sLoad_hit || sStore_hit) |=> !(sLoad_hit || sStore_hit));
    a_activity_implies_busy: assert property (@(posedge CLK) disable iff (RST)
        (mem_ren || mem_wen || sLoad_hit || sStore_hit) |-> busy);
endmodule
